// File: rtl/mc_proc_pkg.sv
// Shared opcodes, function codes, instruction layout and FSM states for the multi-cycle core.
package mc_proc_pkg;

  localparam logic [3:0] OP_ALUR  = 4'b0000;
  localparam logic [3:0] OP_ALUI  = 4'b1000;
  localparam logic [3:0] OP_CMPR  = 4'b0010;
  localparam logic [3:0] OP_CMPI  = 4'b1010;
  localparam logic [3:0] OP_BCOND = 4'b0110;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_LW    = 4'b1001;
  localparam logic [3:0] OP_JAL   = 4'b1011;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_XOR = 4'b0110;

  localparam logic [3:0] FN_F   = 4'b0000;
  localparam logic [3:0] FN_EQ  = 4'b0001;
  localparam logic [3:0] FN_LT  = 4'b0010;
  localparam logic [3:0] FN_LTE = 4'b0011;
  localparam logic [3:0] FN_T   = 4'b1000;
  localparam logic [3:0] FN_NE  = 4'b1001;
  localparam logic [3:0] FN_GTE = 4'b1010;
  localparam logic [3:0] FN_GT  = 4'b1011;

  localparam int OP_LSB  = 28;
  localparam int FN_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 12;

  // Field order mirrors the LSB positions above; rs2 overlays imm[15:12].
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  fn;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [15:0] imm;
  } inst_t;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  function automatic logic op_known(input logic [3:0] op);
    case (op)
      OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI,
      OP_BCOND, OP_SW, OP_LW, OP_JAL: op_known = 1'b1;
      default:                        op_known = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    case (op)
      OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI, OP_LW, OP_JAL: writes_rd = 1'b1;
      default:                                          writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_proc_alu.sv
// Combinational ALU and signed compare unit; unknown function codes yield 0.
module mc_proc_alu
  import mc_proc_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic [DBITS-1:0] a,
  input  logic [DBITS-1:0] b,
  input  logic [3:0]       fn,
  input  logic             is_cmp,
  output logic [DBITS-1:0] y
);

  logic eq, lt;

  assign eq = (a == b);
  assign lt = ($signed(a) < $signed(b));

  always_comb begin
    y = '0;
    if (is_cmp) begin
      case (fn)
        FN_F:    y[0] = 1'b0;
        FN_EQ:   y[0] = eq;
        FN_LT:   y[0] = lt;
        FN_LTE:  y[0] = lt | eq;
        FN_T:    y[0] = 1'b1;
        FN_NE:   y[0] = ~eq;
        FN_GTE:  y[0] = ~lt;
        FN_GT:   y[0] = ~(lt | eq);
        default: y    = '0;
      endcase
    end else begin
      case (fn)
        FN_ADD:  y = a + b;
        FN_SUB:  y = a - b;
        FN_AND:  y = a & b;
        FN_OR:   y = a | b;
        FN_XOR:  y = a ^ b;
        default: y = '0;
      endcase
    end
  end

endmodule

// File: rtl/mc_proc_core.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB core with req/ack memory ports.
// Define MC_PROC_CORE_ILLEGAL_TRAP_EN to halt on an undefined opcode instead of treating it as a NOP.
module mc_proc_core
  import mc_proc_pkg::*;
#(
  parameter int               DBITS               = 32,
  parameter int               REG_INDEX_BIT_WIDTH = 4,
  parameter logic [DBITS-1:0] START_PC            = 'h40,
  parameter int               INST_SIZE           = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [DBITS-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DBITS-1:0] dmem_addr,
  output logic [DBITS-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DBITS-1:0] dmem_rdata,
  output logic [DBITS-1:0] pc_out,
  output logic             retired,
  output logic             halted
);

  localparam int RIW  = REG_INDEX_BIT_WIDTH;
  localparam int NREG = 1 << RIW;

  state_e           state_q, state_d;
  logic [DBITS-1:0] pc_q, pc_d;
  inst_t            ir_q, ir_d;
  logic [DBITS-1:0] a_q, a_d;
  logic [DBITS-1:0] b_q, b_d;
  logic [DBITS-1:0] res_q, res_d;
  logic [DBITS-1:0] npc_q, npc_d;
  logic [DBITS-1:0] rf_q [NREG];
  logic [DBITS-1:0] rf_d [NREG];

  logic [RIW-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [DBITS-1:0] simm, off, pc_plus;
  logic [DBITS-1:0] alu_b, alu_y;
  logic [3:0]       alu_fn;
  logic             alu_cmp, reg_b, is_mem, taken;

  assign rd_idx  = RIW'(ir_q.rd);
  assign rs1_idx = RIW'(ir_q.rs1);
  assign rs2_idx = RIW'(ir_q.imm[RS2_LSB+3:RS2_LSB]);

  assign simm    = {{(DBITS-16){ir_q.imm[15]}}, ir_q.imm};
  assign off     = {simm[DBITS-3:0], 2'b00};
  assign pc_plus = pc_q + DBITS'(INST_SIZE);

  assign reg_b   = (ir_q.op == OP_ALUR) || (ir_q.op == OP_CMPR) || (ir_q.op == OP_BCOND);
  assign alu_cmp = (ir_q.op == OP_CMPR) || (ir_q.op == OP_CMPI) || (ir_q.op == OP_BCOND);
  assign is_mem  = (ir_q.op == OP_SW) || (ir_q.op == OP_LW);
  // Loads and stores reuse the adder for the effective address.
  assign alu_fn  = is_mem ? FN_ADD : ir_q.fn;
  assign alu_b   = reg_b ? b_q : simm;
  assign taken   = (ir_q.op == OP_BCOND) && alu_y[0];

  mc_proc_alu #(.DBITS(DBITS)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .fn     (alu_fn),
    .is_cmp (alu_cmp),
    .y      (alu_y)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    npc_d   = npc_q;
    rf_d    = rf_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = inst_t'(imem_rdata);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Stores carry their data register in the rd/rt slot.
        a_d     = rf_q[rs1_idx];
        b_d     = (ir_q.op == OP_SW) ? rf_q[rd_idx] : rf_q[rs2_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = (ir_q.op == OP_JAL) ? pc_plus : alu_y;
        if (ir_q.op == OP_JAL)
          npc_d = a_q + off;
        else if (taken)
          npc_d = pc_plus + off;
        else
          npc_d = pc_plus;
        if (is_mem)
          state_d = S_MEM;
`ifdef MC_PROC_CORE_ILLEGAL_TRAP_EN
        else if (!op_known(ir_q.op))
          state_d = S_HALT;
`endif
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (ir_q.op == OP_SW) begin
            pc_d    = npc_q;
            state_d = S_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (writes_rd(ir_q.op))
          rf_d[rd_idx] = res_q;
        pc_d    = npc_q;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= START_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      npc_q   <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      npc_q   <= npc_d;
      rf_q    <= rf_d;
    end
  end

  // Gating with reset keeps the fetch request low while reset is held.
  assign imem_req   = reset && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && (ir_q.op == OP_SW);
  assign dmem_addr  = res_q;
  assign dmem_wdata = b_q;
  assign pc_out     = pc_q;
  assign retired    = (state_q == S_WB) || (dmem_we && dmem_ack);

`ifdef MC_PROC_CORE_ILLEGAL_TRAP_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_proc_core.sv
// Directed bench for mc_proc_core: zero-wait ALU/CMP table plus branch, JAL, stalled LW/SW, reset and illegal-op sequences.
module tb_mc_proc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_out;
  logic        retired, halted;

  mc_proc_core dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc_out     (pc_out),
    .retired    (retired),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] pc;

  bit          s_done, s_stable, s_we;
  int          s_cyc, s_dreq;
  logic [31:0] s_fa, s_daddr, s_wd;

  typedef struct {
    string       nm;
    logic [31:0] inst;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ri(input logic [3:0] op, input logic [3:0] fn,
                                     input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [15:0] imm);
    return {op, fn, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [3:0] op, input logic [3:0] fn,
                                     input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [3:0] rs2);
    return {op, fn, rd, rs1, rs2, 12'h000};
  endfunction

  // Serves one instruction: fetch ack with zero wait, data ack after dlat extra cycles.
  task automatic step(input logic [31:0] inst, input int dlat, input logic [31:0] ld,
                      input bit spur, input int maxc);
    int dw = 0;
    bit got_f = 0;
    s_done = 0; s_cyc = 0; s_fa = '0; s_dreq = 0; s_stable = 1;
    s_we = 0; s_daddr = '0; s_wd = '0;
    while (!s_done && s_cyc < maxc) begin
      @(negedge clk);
      if (imem_req && !got_f) begin s_fa = imem_addr; got_f = 1; end
      imem_ack   = spur | imem_req;
      imem_rdata = imem_req ? inst : 32'hFFFF_FFFF;
      if (dmem_req) begin
        if (s_dreq == 0) s_daddr = dmem_addr;
        else if (dmem_addr !== s_daddr) s_stable = 0;
        s_dreq++;
        s_we = dmem_we;
        s_wd = dmem_wdata;
        dmem_ack   = (dw == dlat);
        dmem_rdata = ld;
        dw++;
      end else begin
        dmem_ack   = spur;
        dmem_rdata = 32'h0BAD_0BAD;
      end
      #1;
      s_cyc++;
      if (retired) s_done = 1;
    end
  endtask

  task automatic do_inst(input string nm, input logic [31:0] inst, input logic [31:0] npc, input bit spur);
    step(inst, 0, 32'h0, spur, 20);
    chk({nm, " done"}, 32'(s_done), 32'd1);
    chk({nm, " pc"}, s_fa, pc);
    chk({nm, " cycles"}, s_cyc, 32'd4);
    pc = npc;
  endtask

  task automatic store_chk(input string nm, input logic [3:0] rt, input logic [31:0] exp);
    step(ri(4'b0101, 4'h0, rt, 4'h0, 16'h0000), 0, 32'h0, 1'b0, 20);
    chk({nm, " st pc"}, s_fa, pc);
    chk({nm, " st we"}, 32'(s_we), 32'd1);
    chk({nm, " st addr"}, s_daddr, 32'h0);
    chk({nm, " value"}, s_wd, exp);
    pc = pc + 32'd4;
  endtask

  initial begin
    tv[0]  = '{"alur add",   rr(4'b0000, 4'h0, 4'h5, 4'h1, 4'h2), 32'h0000_0002};
    tv[1]  = '{"alur sub",   rr(4'b0000, 4'h1, 4'h5, 4'h1, 4'h2), 32'hFFFF_FFF8};
    tv[2]  = '{"alur and",   rr(4'b0000, 4'h4, 4'h5, 4'h1, 4'h2), 32'h0000_0005};
    tv[3]  = '{"alur or",    rr(4'b0000, 4'h5, 4'h5, 4'h1, 4'h2), 32'hFFFF_FFFD};
    tv[4]  = '{"alur xor",   rr(4'b0000, 4'h6, 4'h5, 4'h1, 4'h2), 32'hFFFF_FFF8};
    tv[5]  = '{"alur badfn", rr(4'b0000, 4'h2, 4'h5, 4'h1, 4'h2), 32'h0000_0000};
    tv[6]  = '{"alui sub",   ri(4'b1000, 4'h1, 4'h5, 4'h2, 16'h8000), 32'h0000_8005};
    tv[7]  = '{"alui xor",   ri(4'b1000, 4'h6, 4'h5, 4'h1, 16'h00FF), 32'hFFFF_FF02};
    tv[8]  = '{"alui and",   ri(4'b1000, 4'h4, 4'h5, 4'h1, 16'hFFF0), 32'hFFFF_FFF0};
    tv[9]  = '{"cmpr lt",    rr(4'b0010, 4'h2, 4'h5, 4'h1, 4'h2), 32'h1};
    tv[10] = '{"cmpr gt",    rr(4'b0010, 4'hB, 4'h5, 4'h1, 4'h2), 32'h0};
    tv[11] = '{"cmpr lte",   rr(4'b0010, 4'h3, 4'h5, 4'h1, 4'h1), 32'h1};
    tv[12] = '{"cmpr gte",   rr(4'b0010, 4'hA, 4'h5, 4'h1, 4'h2), 32'h0};
    tv[13] = '{"cmpr ne",    rr(4'b0010, 4'h9, 4'h5, 4'h1, 4'h2), 32'h1};
    tv[14] = '{"cmpr f",     rr(4'b0010, 4'h0, 4'h5, 4'h1, 4'h1), 32'h0};
    tv[15] = '{"cmpr t",     rr(4'b0010, 4'h8, 4'h5, 4'h1, 4'h2), 32'h1};
    tv[16] = '{"cmpr badfn", rr(4'b0010, 4'h4, 4'h5, 4'h1, 4'h1), 32'h0};
    tv[17] = '{"cmpi eq",    ri(4'b1010, 4'h1, 4'h5, 4'h1, 16'hFFFD), 32'h1};
    tv[18] = '{"cmpi lt",    ri(4'b1010, 4'h2, 4'h5, 4'h1, 16'hFFFD), 32'h0};
    tv[19] = '{"alui wrap",  ri(4'b1000, 4'h0, 4'h5, 4'h1, 16'h0005), 32'h0000_0002};
    tv[20] = '{"cmpi gt",    ri(4'b1010, 4'hB, 4'h5, 4'h2, 16'hFFFF), 32'h1};

    reset = 1'b0; imem_ack = 0; imem_rdata = '0; dmem_ack = 0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst dmem_we",  32'(dmem_we),  32'd0);
    chk("rst retired",  32'(retired),  32'd0);
    chk("rst halted",   32'(halted),   32'd0);
    chk("rst pc",       pc_out,        32'h40);
    reset = 1'b1;
    pc = 32'h40;

    do_inst("alui r1=5", ri(4'b1000, 4'h0, 4'h1, 4'h0, 16'h0005), 32'h44, 1'b0);
    store_chk("r1=5", 4'h1, 32'h5);
    do_inst("r1=-3", ri(4'b1000, 4'h0, 4'h1, 4'h0, 16'hFFFD), pc + 32'd4, 1'b0);
    do_inst("r2=5",  ri(4'b1000, 4'h0, 4'h2, 4'h0, 16'h0005), pc + 32'd4, 1'b0);

    for (int i = 0; i < 21; i++) begin
      do_inst(tv[i].nm, tv[i].inst, pc + 32'd4, 1'(i % 2));
      store_chk(tv[i].nm, 4'h5, tv[i].exp);
    end

    // Branch: rs2 sits in imm[15:12], so imm=-2 compares r1 against r15.
    do_inst("r1=7",  ri(4'b1000, 4'h0, 4'h1, 4'h0, 16'h0007), pc + 32'd4, 1'b0);
    do_inst("r15=7", ri(4'b1000, 4'h0, 4'hF, 4'h0, 16'h0007), pc + 32'd4, 1'b0);
    do_inst("jal to 50", ri(4'b1011, 4'h0, 4'hE, 4'h0, 16'h0014), 32'h50, 1'b0);
    do_inst("bcond eq taken", ri(4'b0110, 4'h1, 4'h0, 4'h1, 16'hFFFE), 32'h4C, 1'b0);
    do_inst("r15=8", ri(4'b1000, 4'h0, 4'hF, 4'h0, 16'h0008), 32'h50, 1'b0);
    do_inst("bcond eq fall", ri(4'b0110, 4'h1, 4'h0, 4'h1, 16'hFFFE), 32'h54, 1'b0);

    do_inst("r3=100", ri(4'b1000, 4'h0, 4'h3, 4'h0, 16'h0100), 32'h58, 1'b0);
    do_inst("jal to 60", ri(4'b1011, 4'h0, 4'hE, 4'h0, 16'h0018), 32'h60, 1'b0);
    do_inst("jal r3,r3", ri(4'b1011, 4'h0, 4'h3, 4'h3, 16'h0001), 32'h104, 1'b0);
    store_chk("jal link r3", 4'h3, 32'h64);
    store_chk("jal link r14", 4'hE, 32'h5C);

    step(ri(4'b1001, 4'h0, 4'h4, 4'h0, 16'h0010), 3, 32'hDEAD_BEEF, 1'b0, 30);
    chk("lw done",    32'(s_done),   32'd1);
    chk("lw pc",      s_fa,          pc);
    chk("lw cycles",  s_cyc,         32'd8);
    chk("lw req cyc", s_dreq,        32'd4);
    chk("lw stable",  32'(s_stable), 32'd1);
    chk("lw we",      32'(s_we),     32'd0);
    chk("lw addr",    s_daddr,       32'h10);
    pc = pc + 32'd4;
    store_chk("lw data", 4'h4, 32'hDEAD_BEEF);

    step(ri(4'b0101, 4'h0, 4'h2, 4'h3, 16'hFFFC), 2, 32'h0, 1'b1, 30);
    chk("sw stall done",   32'(s_done),   32'd1);
    chk("sw stall cycles", s_cyc,         32'd6);
    chk("sw stall req",    s_dreq,        32'd3);
    chk("sw stall stable", 32'(s_stable), 32'd1);
    chk("sw stall addr",   s_daddr,       32'h60);
    chk("sw stall data",   s_wd,          32'h5);
    pc = pc + 32'd4;

    begin : rst_mid_mem
      bit got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        imem_ack   = imem_req;
        imem_rdata = imem_req ? ri(4'b0101, 4'h0, 4'h2, 4'h0, 16'h0000) : 32'hFFFF_FFFF;
        dmem_ack   = 1'b0;
        if (dmem_req) got = 1;
      end
      chk("mid mem reached", 32'(got), 32'd1);
      @(negedge clk);
      imem_ack = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("mid rst dmem_req", 32'(dmem_req), 32'd0);
      chk("mid rst imem_req", 32'(imem_req), 32'd0);
      chk("mid rst retired",  32'(retired),  32'd0);
      chk("mid rst pc",       pc_out,        32'h40);
      @(negedge clk);
      reset = 1'b1;
      pc = 32'h40;
    end
    store_chk("regs cleared", 4'h1, 32'h0);

`ifdef MC_PROC_CORE_ILLEGAL_TRAP_EN
    step(32'hF000_0000, 0, 32'h0, 1'b0, 8);
    chk("illegal no retire", 32'(s_done),   32'd0);
    chk("illegal pc",        s_fa,          32'h44);
    chk("illegal halted",    32'(halted),   32'd1);
    chk("illegal no fetch",  32'(imem_req), 32'd0);
    chk("illegal pc frozen", pc_out,        32'h44);
`else
    do_inst("illegal nop", 32'hF000_0000, 32'h48, 1'b0);
    chk("illegal halted", 32'(halted), 32'd0);
    store_chk("after nop", 4'h0, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_proc_core.md
Name: mc_proc_core

Overview:
- Multi-cycle, parametrised successor to the single-cycle processor datapath.
- Same ISA subset (ALUR, ALUI, CMPR, CMPI, BCOND, SW, LW, JAL), run as FETCH/DECODE/EXEC/MEM/WB states.
- Instruction and data memories sit behind req/ack handshakes, so variable-latency memories and the memory-mapped I/O block can stall the core.
- Contains its own register file and ALU. Sits between the PLL-clocked top level and the memory/IO subsystem.

Parameters:
- DBITS, 32, datapath and address width.
- REG_INDEX_BIT_WIDTH, 4, register index width; register count = 1<<REG_INDEX_BIT_WIDTH.
- START_PC, 32'h40, PC value on reset.
- INST_SIZE, 4, PC increment in bytes.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  DBITS  fetch address (= PC)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DBITS  effective address
- dmem_wdata  out  DBITS  store data
- dmem_ack  in  1  access complete; load data valid
- dmem_rdata  in  DBITS  load data
- pc_out  out  DBITS  current PC
- retired  out  1  one-cycle pulse when an instruction completes
- halted  out  1  core stopped (optional feature only; otherwise tied 0)

Behaviour:
- Reset (reset=0, async):
  - PC=START_PC, state=FETCH, all registers=0.
  - imem_req, dmem_req, dmem_we, retired, halted all 0.
  - Release mid-instruction discards any in-flight access.
- Instruction format:
  - op1 [31:28], fn [27:24], rd/rt [23:20], rs1 [19:16], imm [15:0].
  - For ALUR/CMPR/BCOND, rs2 is [15:12].
- Opcodes (op1): ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, BCOND 0110, SW 0101, LW 1001, JAL 1011.
- ALU functions (fn): ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 0110.
- Compare functions (fn): F 0000, EQ 0001, LT 0010, LTE 0011, T 1000, NE 1001, GTE 1010, GT 1011.
  - Compares are signed.
  - CMP writes 1 or 0 to rd.
- Immediates are sign-extended from 16 bits. Branch/JAL offset = sext(imm)<<2.
- FETCH:
  - imem_req=1, held until imem_ack.
  - Instruction latched on the ack cycle; ack may arrive in the same cycle as req.
  - Then DECODE.
- DECODE: read operands, then EXEC.
- EXEC: compute result, effective address, or branch target.
  - SW/LW go to MEM; all others go to WB.
- MEM:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata held stable until dmem_ack.
  - SW: on ack, PC+=INST_SIZE, retire, go to FETCH.
  - LW: on ack, latch load data, go to WB.
- WB (one cycle, retired=1):
  - Write rd where applicable.
  - BCOND taken: PC = PC+INST_SIZE+offset; otherwise PC+INST_SIZE.
  - JAL: rd = PC+INST_SIZE; PC = rs1+offset. When rd==rs1, the jump uses the old rs1 value.
- Zero-wait latency: FETCH(1)+DECODE(1)+EXEC(1)+WB/MEM(1) = 4 cycles; LW = 5 cycles.
- Arithmetic wraps modulo 2^DBITS. PC wraps past all-ones.
- Undefined op1: treated as a NOP (PC advances, retired pulses).
- Undefined fn: result 0; BCOND not taken.
- Stalls: an ack arriving while the core is not requesting is ignored.

Optional Feature:
- Macro MC_PROC_CORE_ILLEGAL_TRAP_EN.
- Defined: undefined op1 moves EXEC to a terminal HALT state.
  - halted=1, no further requests, PC frozen at the offending instruction, no retired pulse.
  - Only reset exits HALT.
- Undefined: undefined op1 behaves as a NOP; halted is tied 0.

Decomposition:
- Shared package mc_proc_pkg holds:
  - opcode and fn localparams
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - instruction field bit positions
- One natural sub-module: mc_proc_alu, combinational ALU plus compare unit. The register file stays inline.

Test Plan:
- Reset release, zero-wait memory, ALUI ADD r1=r0+5 → imem_addr=0x40; r1=5 after 4 cycles; retired pulses once; next fetch at 0x44.
- LW with dmem_ack delayed 3 cycles, rdata=0xDEADBEEF → dmem_req held 4 cycles with stable addr; rd=0xDEADBEEF; instruction takes 8 cycles.
- BCOND EQ, r1=r2=7, imm=-2 at PC 0x50 → next PC=0x4C. Same test with r2=8 → next PC=0x54.
- JAL r3,r3 with r3=0x100, imm=1, at PC 0x60 → r3=0x64, PC=0x104.
- Reset asserted mid-MEM during a pending SW → dmem_req drops immediately; no write is observed; PC=0x40.
- Undefined op1 0xF → with the macro: halted=1 and no further imem_req. Without the macro: PC+=4 and a retired pulse.
